// File: rtl/ras_predictor.sv
// Return-address stack for the fetch stage: calls push PC+4, `jr $ra` pops and
// offers the popped address as the predicted next PC.
module ras_predictor #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                instrf,
  input  logic [WIDTH-1:0]           pcplus4f,
  input  logic                       validf,
  input  logic                       flushe,
  output logic                       predict,
  output logic [WIDTH-1:0]           predpc,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [5:0]       op;
  logic [5:0]       funct;
  logic [4:0]       rs;
  logic             is_call;
  logic             is_ret;
  logic             do_push;
  logic             do_pop;

  logic [AW-1:0]    tos_reg;
  logic [AW-1:0]    tos_next;
  logic [AW-1:0]    push_idx;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic [WIDTH-1:0] mem_reg [DEPTH];

  assign op    = instrf[31:26];
  assign funct = instrf[5:0];
  assign rs    = instrf[25:21];

  // jalr is a call whatever its rs; only jr through $ra counts as a return
  assign is_call = (op == 6'b000011) || ((op == 6'b000000) && (funct == 6'b001001));
  assign is_ret  = (op == 6'b000000) && (funct == 6'b001000) && (rs == 5'd31);

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));
  assign count = count_reg;

  assign do_push  = is_call && validf && !flushe;
  assign do_pop   = is_ret && validf && !flushe && !empty;
  assign push_idx = tos_reg + 1'b1;

  // predict depends only on registered state and instrf, never on flushe
  assign predict = is_ret && !empty;
  assign predpc  = mem_reg[tos_reg];

  always_comb begin
    tos_next   = tos_reg;
    count_next = count_reg;
    if (flushe) begin
      tos_next   = '0;
      count_next = '0;
    end else if (do_push) begin
      tos_next = push_idx;
      if (!full) begin
        count_next = count_reg + 1'b1;
      end
    end else if (do_pop) begin
      tos_next   = tos_reg - 1'b1;
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tos_reg   <= '0;
      count_reg <= '0;
    end else begin
      tos_reg   <= tos_next;
      count_reg <= count_next;
    end
  end

  // Entries are cleared on reset so predpc reads zero until the first call
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (do_push) begin
      mem_reg[push_idx] <= pcplus4f;
    end
  end

endmodule

// File: tb/tb_ras_predictor.sv
// Randomized and directed check of ras_predictor against a queue-based stack model,
// with expected outputs scoreboarded and compared by an independent monitor.
module tb_ras_predictor;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH+1);

  localparam logic [31:0] JAL   = 32'h0C00_0000;
  localparam logic [31:0] JR_RA = 32'h03E0_0008;
  localparam logic [31:0] JR_T0 = 32'h0100_0008;
  localparam logic [31:0] JALR  = 32'h0100_F809;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [31:0]      instrf = '0;
  logic [WIDTH-1:0] pcplus4f = '0;
  logic             validf = 1'b0;
  logic             flushe = 1'b0;
  logic             predict;
  logic [WIDTH-1:0] predpc;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;

  always #5 clk = ~clk;

  ras_predictor #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .instrf(instrf), .pcplus4f(pcplus4f),
    .validf(validf), .flushe(flushe), .predict(predict), .predpc(predpc),
    .empty(empty), .full(full), .count(count)
  );

  typedef struct {
    int               cyc;
    logic             predict;
    logic             chk_pc;
    logic [WIDTH-1:0] pc;
    int               cnt;
  } exp_t;

  exp_t             sbq[$];
  logic [WIDTH-1:0] stk[$];
  bit               written = 1'b0;
  int               cyc = 0;
  int               n_cmp = 0;
  int               n_bad = 0;

  function automatic bit is_call(logic [31:0] i);
    return (i[31:26] == 6'd3) || (i[31:26] == 6'd0 && i[5:0] == 6'd9);
  endfunction

  function automatic bit is_ret(logic [31:0] i);
    return (i[31:26] == 6'd0) && (i[5:0] == 6'd8) && (i[25:21] == 5'd31);
  endfunction

  function automatic void check(string nm, int c, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, c, got, want);
    end
  endfunction

  // Drive one fetch cycle, record what the outputs must show, then apply the stack rules.
  task automatic step(input logic [31:0] ins, input logic [WIDTH-1:0] pc4,
                      input logic v, input logic fl, input logic rst);
    exp_t e;
    instrf = ins; pcplus4f = pc4; validf = v; flushe = fl; reset = rst;
    e.cyc     = cyc;
    e.predict = is_ret(ins) && (stk.size() > 0);
    e.chk_pc  = e.predict || !written;
    e.pc      = e.predict ? stk[$] : '0;
    e.cnt     = stk.size();
    sbq.push_back(e);
    $display("cyc=%0d instr=%08h pc4=%0h v=%0b fl=%0b rst=%0b exp_pred=%0b exp_cnt=%0d",
             cyc, ins, pc4, v, fl, rst, e.predict, e.cnt);
    @(posedge clk);
    if (rst) begin
      stk.delete();
      written = 1'b0;
    end else if (fl) begin
      stk.delete();
    end else if (v && is_call(ins)) begin
      stk.push_back(pc4);
      written = 1'b1;
      if (stk.size() > DEPTH) void'(stk.pop_front());
    end else if (v && is_ret(ins) && stk.size() > 0) begin
      void'(stk.pop_back());
    end
    #1;
    cyc++;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("predict", e.cyc, 32'(predict), 32'(e.predict));
        if (e.chk_pc) check("predpc", e.cyc, 32'(predpc), 32'(e.pc));
        check("count", e.cyc, 32'(count), 32'(e.cnt));
        check("empty", e.cyc, 32'(empty), 32'(e.cnt == 0));
        check("full", e.cyc, 32'(full), 32'(e.cnt == DEPTH));
      end
    end
  end

  initial begin
    logic [31:0] ins;
    repeat (2) @(posedge clk);
    #1;
    step(NOP, '0, 1'b0, 1'b0, 1'b1);
    // single call/return
    step(JAL, 32'h0040_0008, 1'b1, 1'b0, 1'b0);
    step(JR_RA, 32'h0, 1'b1, 1'b0, 1'b0);
    step(NOP, 32'h0, 1'b1, 1'b0, 1'b0);
    // nesting
    step(JAL, 32'h100, 1'b1, 1'b0, 1'b0);
    step(JAL, 32'h200, 1'b1, 1'b0, 1'b0);
    step(JAL, 32'h300, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(JR_RA, 32'h0, 1'b1, 1'b0, 1'b0);
    // overflow
    for (int i = 1; i <= 9; i++) step(JAL, 32'(i * 16), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(JR_RA, 32'h0, 1'b1, 1'b0, 1'b0);
    // jr through another register, jalr
    step(JR_T0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(JALR, 32'h500, 1'b1, 1'b0, 1'b0);
    step(JR_RA, 32'h0, 1'b1, 1'b0, 1'b0);
    // stalled fetch
    step(NOP, 32'h0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(JAL, 32'h700, 1'b0, 1'b0, 1'b0);
    step(JAL, 32'h700, 1'b1, 1'b0, 1'b0);
    step(NOP, 32'h0, 1'b1, 1'b0, 1'b0);
    // flush beats a same-cycle push
    step(JAL, 32'h810, 1'b1, 1'b0, 1'b0);
    step(JAL, 32'h820, 1'b1, 1'b0, 1'b0);
    step(JAL, 32'h830, 1'b1, 1'b1, 1'b0);
    step(JR_RA, 32'h0, 1'b1, 1'b0, 1'b0);
    // reset beats a pending call
    step(JAL, 32'h840, 1'b1, 1'b0, 1'b0);
    step(JAL, 32'h999, 1'b1, 1'b0, 1'b1);
    step(JR_RA, 32'h0, 1'b1, 1'b0, 1'b0);
    // random traffic
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 6))
        0, 1:    ins = JAL | ($urandom & 32'h03FF_FFFF);
        2:       ins = {6'd0, 5'($urandom), 5'd0, 5'($urandom), 5'd0, 6'd9};
        3, 4:    ins = JR_RA;
        5:       ins = {6'd0, 5'($urandom), 15'd0, 6'd8};
        default: ins = $urandom;
      endcase
      step(ins, $urandom & 32'hFFFF_FFFC, ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 29) == 0), ($urandom_range(0, 199) == 0));
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
